// File: rtl/fft_bitrev_stream_buffer.sv
// Ping-pong sample reorder buffer ahead of the FFT core: frames are written in
// natural order into one bank while the other bank drains in bit-reversed (or natural) order.
module fft_bitrev_stream_buffer #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             bitrev_en_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_first_o,
  output logic             out_last_o
);

  localparam int IDXW = $clog2(SAMPLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SAMPLES - 1);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  logic [WIDTH-1:0] mem_q [2][SAMPLES];
  logic [1:0]       st_q [2];
  logic [1:0]       st_d [2];
  logic [1:0]       mode_q, mode_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IDXW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [WIDTH-1:0] last_q, last_d;

  logic             wr_fire, rd_fire;
  logic [IDXW-1:0]  rd_addr;
  logic [WIDTH-1:0] rd_word;

  function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] v);
    logic [IDXW-1:0] r;
    for (int i = 0; i < IDXW; i++) r[i] = v[IDXW-1-i];
    return r;
  endfunction

  assign in_ready_o  = (st_q[wr_bank_q] == ST_EMPTY) || (st_q[wr_bank_q] == ST_FILLING);
  assign out_valid_o = (st_q[rd_bank_q] == ST_FULL) || (st_q[rd_bank_q] == ST_DRAINING);
  assign wr_fire     = in_valid_i && in_ready_o;
  assign rd_fire     = out_valid_o && out_ready_i;

  assign rd_addr     = mode_q[rd_bank_q] ? bitrev(rd_cnt_q) : rd_cnt_q;
  assign rd_word     = mem_q[rd_bank_q][rd_addr];

  // Combinational read mux; when idle, present the last sample handed out.
  assign out_data_o  = out_valid_o ? rd_word : last_q;
  assign out_first_o = out_valid_o && (rd_cnt_q == '0);
  assign out_last_o  = out_valid_o && (rd_cnt_q == LAST_IDX);

  always_comb begin
    st_d      = st_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    last_d    = last_q;

    // Write and read always target different banks, so both updates can apply.
    if (wr_fire) begin
      if (wr_cnt_q == '0) begin
        st_d[wr_bank_q]   = ST_FILLING;
        mode_d[wr_bank_q] = bitrev_en_i;
      end
      if (wr_cnt_q == LAST_IDX) begin
        st_d[wr_bank_q] = ST_FULL;
        wr_cnt_d        = '0;
        wr_bank_d       = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + IDXW'(1);
      end
    end

    if (rd_fire) begin
      last_d = rd_word;
      if (rd_cnt_q == LAST_IDX) begin
        st_d[rd_bank_q] = ST_EMPTY;
        rd_cnt_d        = '0;
        rd_bank_d       = ~rd_bank_q;
      end else begin
        st_d[rd_bank_q] = ST_DRAINING;
        rd_cnt_d        = rd_cnt_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q[0]   <= ST_EMPTY;
      st_q[1]   <= ST_EMPTY;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      last_q    <= '0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      last_q    <= last_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < SAMPLES; s++)
          mem_q[b][s] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_stream_buffer.sv
// Directed bench for fft_bitrev_stream_buffer (SAMPLES=8, WIDTH=16): frame order,
// flags, latency, back-to-back streaming, backpressure, per-frame mode and reset.
module tb_fft_bitrev_stream_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        bitrev_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] oq[$];
  bit          fq[$];
  bit          lq[$];
  int          tq[$];
  int          itq[$];
  int          ir_stall;

  logic [2:0] br_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  fft_bitrev_stream_buffer #(.SAMPLES(8), .WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .bitrev_en_i(bitrev_en),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_first_o(out_first),
    .out_last_o (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Record every handshake that the coming rising edge will complete.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) itq.push_back(cyc);
      if (in_valid && !in_ready) ir_stall++;
      if (out_valid && out_ready) begin
        oq.push_back(out_data);
        fq.push_back(out_first);
        lq.push_back(out_last);
        tq.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    oq.delete(); fq.delete(); lq.delete(); tq.delete(); itq.delete();
    ir_stall = 0;
  endtask

  // Entered and left at posedge+1; in_valid stays high on return.
  task automatic send(input logic [15:0] d, input logic br);
    bit ok = 0;
    bit r;
    in_data = d; in_valid = 1'b1; bitrev_en = br;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: sample %0d not accepted within 100 cycles", d);
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; bitrev_en = 0; out_ready = 0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_first !== 1'b0) begin errors++; $display("FAIL rst_out_first: got %b want 0", out_first); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic test_bitrev_frame();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(i), 1'b1);
    idle_cycles(12);
    checks++; if (oq.size() != 8) begin errors++; $display("FAIL br_count: got %0d want 8", oq.size()); end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      checks++; if (oq[i] !== 16'(br_tab[i])) begin errors++; $display("FAIL br_data[%0d]: got %0d want %0d", i, oq[i], br_tab[i]); end
      checks++; if (fq[i] !== (i == 0)) begin errors++; $display("FAIL br_first[%0d]: got %b", i, fq[i]); end
      checks++; if (lq[i] !== (i == 7)) begin errors++; $display("FAIL br_last[%0d]: got %b", i, lq[i]); end
    end
    if (oq.size() == 8 && itq.size() == 8) begin
      checks++; if (tq[0] != itq[7] + 1) begin errors++; $display("FAIL br_latency: first out cycle %0d want %0d", tq[0], itq[7] + 1); end
      checks++; if (tq[0] != itq[0] + 8) begin errors++; $display("FAIL br_in_to_out: got %0d want %0d", tq[0] - itq[0], 8); end
    end
  endtask

  task automatic test_bypass();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(10 + i), 1'b0);
    idle_cycles(12);
    checks++; if (oq.size() != 8) begin errors++; $display("FAIL by_count: got %0d want 8", oq.size()); end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      checks++; if (oq[i] !== 16'(10 + i)) begin errors++; $display("FAIL by_data[%0d]: got %0d want %0d", i, oq[i], 10 + i); end
      checks++; if (fq[i] !== (i == 0) || lq[i] !== (i == 7)) begin errors++; $display("FAIL by_flags[%0d]: got first=%b last=%b", i, fq[i], lq[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) send(16'(100 + 8 * f + i), 1'b1);
    idle_cycles(12);
    checks++; if (ir_stall != 0) begin errors++; $display("FAIL b2b_in_stall: got %0d stall cycles want 0", ir_stall); end
    checks++; if (oq.size() != 24) begin errors++; $display("FAIL b2b_count: got %0d want 24", oq.size()); end
    for (int j = 0; j < 24 && j < oq.size(); j++) begin
      checks++;
      if (oq[j] !== 16'(100 + 8 * (j / 8) + br_tab[j % 8])) begin
        errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", j, oq[j], 100 + 8 * (j / 8) + br_tab[j % 8]);
      end
    end
    if (oq.size() == 24) begin
      checks++; if (tq[23] - tq[0] != 23) begin errors++; $display("FAIL b2b_gapless: span %0d want 23", tq[23] - tq[0]); end
    end
  endtask

  task automatic test_full_stall();
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'(200 + i), 1'b1);
    in_data = 16'd216;
    repeat (5) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 16'd200 || out_first !== 1'b1) begin
        errors++; $display("FAIL full_hold: got valid=%b data=%0d first=%b want 1/200/1", out_valid, out_data, out_first);
      end
    end
    @(posedge clk); #1;
    checks++; if (itq.size() != 16) begin errors++; $display("FAIL full_accepted: got %0d want 16", itq.size()); end
    out_ready = 1'b1;
    for (int i = 16; i < 24; i++) send(16'(200 + i), 1'b1);
    idle_cycles(20);
    checks++; if (oq.size() != 24) begin errors++; $display("FAIL full_count: got %0d want 24", oq.size()); end
    for (int j = 0; j < 24 && j < oq.size(); j++) begin
      checks++;
      if (oq[j] !== 16'(200 + 8 * (j / 8) + br_tab[j % 8])) begin
        errors++; $display("FAIL full_data[%0d]: got %0d want %0d", j, oq[j], 200 + 8 * (j / 8) + br_tab[j % 8]);
      end
    end
  endtask

  task automatic test_mode_toggle();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(40 + i), (i < 3) ? 1'b1 : 1'b0);
    for (int i = 0; i < 8; i++) send(16'(50 + i), (i < 3) ? 1'b0 : 1'b1);
    idle_cycles(14);
    checks++; if (oq.size() != 16) begin errors++; $display("FAIL mode_count: got %0d want 16", oq.size()); end
    for (int j = 0; j < 8 && j < oq.size(); j++) begin
      checks++; if (oq[j] !== 16'(40 + br_tab[j])) begin errors++; $display("FAIL mode_a[%0d]: got %0d want %0d", j, oq[j], 40 + br_tab[j]); end
    end
    for (int j = 8; j < 16 && j < oq.size(); j++) begin
      checks++; if (oq[j] !== 16'(42 + j)) begin errors++; $display("FAIL mode_b[%0d]: got %0d want %0d", j, oq[j], 42 + j); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(16'(60 + i), 1'b1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(i), 1'b1);
    idle_cycles(14);
    checks++; if (oq.size() != 8) begin errors++; $display("FAIL mid_count: got %0d want 8", oq.size()); end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      checks++; if (oq[i] !== 16'(br_tab[i])) begin errors++; $display("FAIL mid_data[%0d]: got %0d want %0d", i, oq[i], br_tab[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_bitrev_frame();
    test_bypass();
    test_back_to_back();
    test_full_stall();
    test_mode_toggle();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
